ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the 16x8 RAM16 macro between the BE8 CPU bus (MAR/RI/RO) and an external host loader port.
//  Also sequences a clear pass that writes CLEAR_VALUE to all 16 locations.
//  Sits between the CPU control word, the host interface and the RAM wrapper; it is the only driver of RAM ADDR/DIN/WE.
//  CPU has priority. A starvation counter guarantees the host one slot every STARVE_LIMIT+1 waiting cycles.
// PARAMETERS
//  STARVE_LIMIT    4      host cycles waited (req high, no gnt) before host is forced a slot; range 1..15
//  CLEAR_ON_RESET  1      1: clear pass starts automatically on reset release; 0: only on clear_start
//  CLEAR_VALUE     8'h00  byte written by clear pass
// PORTS
//  CLK          in   1  system clock, all state on rising edge
//  RESETn       in   1  asynchronous, active-low reset
//  cpu_addr     in   4  CPU RAM address (MAR)
//  cpu_wdata    in   8  CPU write data (bus)
//  cpu_we       in   1  CPU write request (RI)
//  cpu_re       in   1  CPU read request (RO)
//  cpu_rdata    out  8  CPU read data, valid with cpu_rvalid
//  cpu_rvalid   out  1  one-cycle pulse, read data for request accepted previous cycle
//  cpu_stall    out  1  CPU request not served this cycle; CPU must hold request
//  host_req     in   1  host access request; hold until granted
//  host_we      in   1  1 write, 0 read (sampled with host_req)
//  host_addr    in   4  host address
//  host_wdata   in   8  host write data
//  host_gnt     out  1  access performed at this rising edge when host_req&host_gnt
//  host_rvalid  out  1  one-cycle pulse, host read data valid
//  host_rdata   out  8  host read data, held until next host read completes
//  clear_start  in   1  pulse: begin clear pass (ignored while busy)
//  busy         out  1  clear pass in progress
//  ram_addr     out  4  to RAM ADDR
//  ram_din      out  8  to RAM DIN
//  ram_we       out  1  to RAM RI
//  ram_dout     in   8  from RAM DOUT; 1-cycle registered read, reads 0 during write cycles
// BEHAVIOUR
//  Reset: state CLEAR with clr_addr=0 if CLEAR_ON_RESET, else IDLE. All outputs are 0 except busy.
//   busy=CLEAR_ON_RESET. Starve counter=0. host_rdata=0, cpu_rdata=0.
//  FSM: CLEAR -> IDLE after writing addr 15. IDLE -> CLEAR on clear_start. No other states.
//  CLEAR: ram_we=1, ram_addr=clr_addr, ram_din=CLEAR_VALUE, clr_addr++ each cycle, 16 cycles exactly.
//   cpu_stall=1 if cpu_we|cpu_re. host_gnt=0. clear_start ignored.
//  IDLE arbitration (combinational, per cycle):
//   force_host = host_req & (starve==STARVE_LIMIT).
//   CPU wins if (cpu_we|cpu_re) & !force_host; else host wins if host_req; else RAM idle (ram_we=0).
//   cpu_stall = (cpu_we|cpu_re) & !cpu_wins. cpu_we and cpu_re both high: write wins, no rvalid.
//  Winner drives ram_addr/ram_din/ram_we. Read winner: rvalid pulses next cycle; rdata registered from ram_dout.
//  Starve counter: +1 when host_req & !host_gnt (saturates at STARVE_LIMIT). Cleared on host grant or !host_req.
//  Latency: write = 0 (commits at grant edge); read = 1 cycle from grant edge.
//  Back-to-back reads from either port are allowed every cycle.
//  Reset mid-clear: restarts clear from addr 0 (if CLEAR_ON_RESET). Pending rvalid is dropped.
//  Address wrap: clr_addr 4-bit, terminates on 15, never wraps into a 17th write.
// STRUCTURE
//  be8_pkg: ADDR_W=4, DATA_W=8, typedef enum {ARB_IDLE, ARB_CLEAR} arb_state_t.
//  Sub-module ram_clear_seq: clr_addr counter + busy + done; arbiter muxes its outputs.
// TESTING
//  Reset, CLEAR_ON_RESET=1 -> busy 16 cycles, ram_we=1 addr 0..15 data 00; then host read addr 7 -> rdata 00.
//  Host write 3<=A5 then host read 3 -> host_gnt each; host_rvalid one cycle after read grant, host_rdata=A5.
//  CPU cpu_re continuous + host_req, STARVE_LIMIT=4:
//   host granted on 5th waiting cycle, cpu_stall=1 that cycle only, then CPU resumes.
//  Same-cycle cpu_we addr 2=11 and host write addr 2=22, no starvation -> CPU wins; host wins next; RAM[2]=22.
//  clear_start after writes, cpu_we during clear -> cpu_stall=1 for 16 cycles; all locations read 00 afterwards.
//  RESETn low at clear cycle 8 -> clear restarts at addr 0; host_rvalid/cpu_rvalid never pulse during reset.

Source files
------------

// File: rtl/be8_pkg.sv
// Shared types and sizes for the BE8 RAM port arbiter slice.
package be8_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 16;
  localparam int STARVE_W  = 4;

  // Arbiter has only two modes: normal arbitration or the clear pass.
  typedef enum logic {
    ARB_IDLE,
    ARB_CLEAR
  } arb_state_t;

  // Last RAM location; the clear pass stops after writing it.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

endpackage

// File: rtl/ram_clear_seq.sv
// Clear-pass sequencer: steps an address through all RAM locations exactly once.
// The arbiter muxes clr_addr onto the RAM while busy is high.
module ram_clear_seq
  import be8_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              done
);

  // Address counter and busy flag; a pass ends on the last address and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
      busy     <= CLEAR_ON_RESET;
    end else if (busy) begin
      if (clr_addr == LAST_ADDR) begin
        clr_addr <= '0;
        busy     <= 1'b0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end else if (start) begin
      clr_addr <= '0;
      busy     <= 1'b1;
    end
  end

  // Done marks the cycle in which the final location is being written.
  always_comb begin
    done = busy && (clr_addr == LAST_ADDR);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port 16x8 RAM between the CPU bus and a host loader port,
// and runs a clear pass that fills every location with CLEAR_VALUE.
// CPU has priority; a starvation counter forces a host slot after STARVE_LIMIT waits.
module ram_port_arbiter
  import be8_pkg::*;
#(
  parameter int               STARVE_LIMIT   = 4,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE   = 8'h00
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [ADDR_W-1:0]   clr_addr;
  logic                clr_busy;
  logic                clr_done;
  logic                clr_start;
  logic [STARVE_W-1:0] starve;
  logic                cpu_req;
  logic                force_host;
  logic                cpu_wins;
  logic                host_wins;
  logic                cpu_rd_accept;
  logic                host_rd_accept;
  logic                cpu_rd_pend;
  logic                host_rd_pend;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   host_rdata_q;

  // A clear request is only honoured while arbitrating normally.
  always_comb begin
    clr_start = (state == ARB_IDLE) && clear_start;
  end

  ram_clear_seq #(
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk     (CLK),
    .rst_n   (RESETn),
    .start   (clr_start),
    .clr_addr(clr_addr),
    .busy    (clr_busy),
    .done    (clr_done)
  );

  // State register; reset lands in the clear pass when auto-clear is enabled.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= CLEAR_ON_RESET ? ARB_CLEAR : ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter clear on request, leave once the last address is written.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (clear_start) state_next = ARB_CLEAR;
      ARB_CLEAR: if (clr_done)    state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // Request decode and starvation override feeding the arbitration.
  always_comb begin
    cpu_req    = cpu_we | cpu_re;
    force_host = host_req && (starve == STARVE_MAX);
  end

  // Output decode: pick the RAM owner for this cycle and drive the RAM from it.
  always_comb begin
    cpu_wins       = 1'b0;
    host_wins      = 1'b0;
    cpu_stall      = 1'b0;
    host_gnt       = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_din        = '0;
    cpu_rd_accept  = 1'b0;
    host_rd_accept = 1'b0;
    if (state == ARB_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_din   = CLEAR_VALUE;
      cpu_stall = cpu_req;
    end else begin
      cpu_wins  = cpu_req && !force_host;
      host_wins = !cpu_wins && host_req;
      cpu_stall = cpu_req && !cpu_wins;
      host_gnt  = host_wins;
      if (cpu_wins) begin
        ram_we        = cpu_we;
        ram_addr      = cpu_addr;
        ram_din       = cpu_wdata;
        cpu_rd_accept = !cpu_we;
      end else if (host_wins) begin
        ram_we         = host_we;
        ram_addr       = host_addr;
        ram_din        = host_wdata;
        host_rd_accept = !host_we;
      end
    end
  end

  // Starvation counter: counts host waiting cycles, saturating at the limit.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      starve <= '0;
    end else if (!host_req || host_gnt) begin
      starve <= '0;
    end else if (starve != STARVE_MAX) begin
      starve <= starve + 1'b1;
    end
  end

  // Read pipeline: flag accepted reads and keep the last returned byte per port.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cpu_rd_pend  <= 1'b0;
      host_rd_pend <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      cpu_rd_pend  <= cpu_rd_accept;
      host_rd_pend <= host_rd_accept;
      if (cpu_rd_pend)  cpu_rdata_q  <= ram_dout;
      if (host_rd_pend) host_rdata_q <= ram_dout;
    end
  end

  // Read data comes straight from the RAM in the valid cycle, then from the hold register.
  always_comb begin
    cpu_rvalid  = cpu_rd_pend;
    host_rvalid = host_rd_pend;
    cpu_rdata   = cpu_rd_pend  ? ram_dout : cpu_rdata_q;
    host_rdata  = host_rd_pend ? ram_dout : host_rdata_q;
    busy        = clr_busy;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// against a cycle-level model built from the arbitration rules and a shadow memory.
module tb_ram_port_arbiter;

  localparam int         STARVE_LIM = 4;
  localparam bit         CLR_ON_RST = 1'b1;
  localparam logic [7:0] CLEAR_VAL  = 8'h00;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic [3:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_we = 1'b0;
  logic       cpu_re = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       cpu_stall;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       clear_start = 1'b0;
  logic       busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] ref_mem [16];
  bit         m_busy;
  int         m_clr;
  int         m_starve;
  bit         m_cpu_rv;
  bit         m_host_rv;
  logic [7:0] m_cpu_rd;
  logic [7:0] m_host_rd;
  bit         last_host_win;

  // RAM macro stand-in
  logic [7:0] ram_mem [16];

  ram_port_arbiter #(
    .STARVE_LIMIT  (STARVE_LIM),
    .CLEAR_ON_RESET(CLR_ON_RST),
    .CLEAR_VALUE   (CLEAR_VAL)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .clear_start(clear_start),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always #5 CLK = ~CLK;

  // Registered-read RAM; reads 0 on write cycles
  always @(posedge CLK) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_dout          <= 8'h00;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy    = CLR_ON_RST;
    m_clr     = 0;
    m_starve  = 0;
    m_cpu_rv  = 0;
    m_host_rv = 0;
    m_cpu_rd  = 8'h00;
    m_host_rd = 8'h00;
    last_host_win = 0;
  endtask

  task automatic idleInputs();
    cpu_we = 0; cpu_re = 0; host_req = 0; host_we = 0; clear_start = 0;
  endtask

  // Hold reset across n rising edges; called at a negedge
  task automatic doReset(input int n);
    idleInputs();
    RESETn = 1'b0;
    #1;
    checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_host_rvalid", host_rvalid, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (CLR_ON_RST) ref_mem[0] = CLEAR_VAL;
      #1;
      checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
      checkOutput("rst_host_rvalid", host_rvalid, 0);
      checkOutput("rst_busy", busy, CLR_ON_RST);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    modelReset();
  endtask

  // One clock cycle with the currently driven inputs; starts and ends at a negedge
  task automatic applyStimulus();
    bit c_req, f_host, c_win, h_win, e_we;
    logic [3:0] e_addr;
    logic [7:0] e_din;
    #1;
    checkOutput("busy", busy, m_busy);
    checkOutput("cpu_rvalid", cpu_rvalid, m_cpu_rv);
    checkOutput("host_rvalid", host_rvalid, m_host_rv);
    checkOutput("cpu_rdata", cpu_rdata, m_cpu_rd);
    checkOutput("host_rdata", host_rdata, m_host_rd);
    c_req = cpu_we | cpu_re;
    c_win = 0; h_win = 0; e_we = 0; e_addr = '0; e_din = '0;
    if (m_busy) begin
      e_we   = 1;
      e_addr = 4'(m_clr);
      e_din  = CLEAR_VAL;
      checkOutput("cpu_stall", cpu_stall, c_req);
    end else begin
      f_host = host_req && (m_starve >= STARVE_LIM);
      c_win  = c_req && !f_host;
      h_win  = host_req && !c_win;
      if (c_win) begin
        e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_wdata;
      end else if (h_win) begin
        e_we = host_we; e_addr = host_addr; e_din = host_wdata;
      end
      checkOutput("cpu_stall", cpu_stall, c_req && !c_win);
    end
    checkOutput("host_gnt", host_gnt, h_win);
    checkOutput("ram_we", ram_we, e_we);
    if (m_busy || c_win || h_win) checkOutput("ram_addr", ram_addr, e_addr);
    if (e_we) checkOutput("ram_din", ram_din, e_din);
    @(posedge CLK);
    m_cpu_rv  = 0;
    m_host_rv = 0;
    if (m_busy) begin
      ref_mem[m_clr] = CLEAR_VAL;
      m_clr++;
      if (m_clr == 16) m_busy = 0;
    end else begin
      if (c_win) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else begin m_cpu_rv = 1; m_cpu_rd = ref_mem[cpu_addr]; end
      end else if (h_win) begin
        if (host_we) ref_mem[host_addr] = host_wdata;
        else begin m_host_rv = 1; m_host_rd = ref_mem[host_addr]; end
      end
      if (clear_start) begin m_busy = 1; m_clr = 0; end
    end
    if (host_req && !h_win) m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
    else m_starve = 0;
    last_host_win = h_win;
    @(negedge CLK);
  endtask

  initial begin
    int busy_cycles, grant_idx, stall_cnt, zero_cnt;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    modelReset();

    // Power-up reset and automatic clear pass
    @(negedge CLK);
    doReset(3);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (busy) busy_cycles++;
      applyStimulus();
    end
    checkOutput("clear_len", busy_cycles, 16);

    // Host read of a cleared location
    host_req = 1; host_we = 0; host_addr = 4'd7;
    applyStimulus();
    host_req = 0;
    #1;
    checkOutput("host_rd7_valid", host_rvalid, 1);
    checkOutput("host_rd7_data", host_rdata, 8'h00);
    applyStimulus();

    // Host write then read back
    host_req = 1; host_we = 1; host_addr = 4'd3; host_wdata = 8'hA5;
    #1;
    checkOutput("host_wr_gnt", host_gnt, 1);
    applyStimulus();
    host_we = 0;
    applyStimulus();
    host_req = 0;
    #1;
    checkOutput("host_rd3_valid", host_rvalid, 1);
    checkOutput("host_rd3_data", host_rdata, 8'hA5);
    applyStimulus();

    // Starvation: continuous CPU reads, host forced in on 5th waiting cycle
    cpu_re = 1; host_req = 1; host_we = 0; host_addr = 4'd3;
    grant_idx = -1; stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cpu_addr = 4'($urandom_range(0, 15));
      #1;
      if (cpu_stall) stall_cnt++;
      if (host_gnt && grant_idx < 0) grant_idx = i;
      applyStimulus();
      if (last_host_win) host_req = 0;
    end
    cpu_re = 0;
    checkOutput("starve_grant_cycle", grant_idx, 4);
    checkOutput("starve_stall_cnt", stall_cnt, 1);
    applyStimulus();

    // Same-cycle write collision on address 2
    cpu_we = 1; cpu_addr = 4'd2; cpu_wdata = 8'h11;
    host_req = 1; host_we = 1; host_addr = 4'd2; host_wdata = 8'h22;
    #1;
    checkOutput("collide_host_gnt0", host_gnt, 0);
    checkOutput("collide_cpu_stall0", cpu_stall, 0);
    applyStimulus();
    cpu_we = 0;
    #1;
    checkOutput("collide_host_gnt1", host_gnt, 1);
    applyStimulus();
    host_req = 1; host_we = 0; host_addr = 4'd2;
    applyStimulus();
    host_req = 0;
    #1;
    checkOutput("collide_rd2", host_rdata, 8'h22);
    applyStimulus();

    // Clear pass with a CPU write held off for the whole pass
    clear_start = 1;
    applyStimulus();
    clear_start = 0;
    cpu_we = 1; cpu_addr = 4'd9; cpu_wdata = 8'h5A;
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (cpu_stall) stall_cnt++;
      applyStimulus();
    end
    cpu_we = 0;
    checkOutput("clear_stall_cnt", stall_cnt, 16);
    zero_cnt = 0;
    for (int i = 0; i <= 16; i++) begin
      cpu_re = (i < 16);
      cpu_addr = 4'(i);
      #1;
      if (cpu_rvalid && cpu_rdata == 8'h00) zero_cnt++;
      applyStimulus();
    end
    checkOutput("clear_all_zero", zero_cnt, 16);

    // Reset while a host read is pending drops the rvalid
    for (int i = 0; i < 16; i++) begin
      host_req = 1; host_we = 1; host_addr = 4'(i); host_wdata = 8'(8'h30 + i);
      applyStimulus();
    end
    host_we = 0; host_addr = 4'd5;
    applyStimulus();
    doReset(1);

    // Reset at clear cycle 8 restarts the pass from address 0
    for (int i = 0; i < 8; i++) applyStimulus();
    doReset(1);
    #1;
    checkOutput("restart_addr0", ram_addr, 0);
    checkOutput("restart_busy", busy, 1);
    for (int i = 0; i < 16; i++) applyStimulus();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cpu_we    = ($urandom_range(0, 3) == 0);
      cpu_re    = ($urandom_range(0, 2) == 0);
      cpu_addr  = 4'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom_range(0, 255));
      if (!host_req || last_host_win) begin
        host_req   = $urandom_range(0, 1) == 1;
        host_we    = $urandom_range(0, 1) == 1;
        host_addr  = 4'($urandom_range(0, 15));
        host_wdata = 8'($urandom_range(0, 255));
      end
      clear_start = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end
    idleInputs();
    for (int i = 0; i < 20; i++) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
